// File: rtl/bitmanip_share_arb_if.sv
// Request/response bundle for the shared bitmanip unit: two requester channels
// and one tagged response channel.
interface bitmanip_share_arb_if #(
   parameter int TAG_W = 4
);
   logic             req0_valid;
   logic             req0_ready;
   logic [2:0]       req0_op;
   logic [31:0]      req0_src1;
   logic [31:0]      req0_src2;
   logic [TAG_W-1:0] req0_tag;

   logic             req1_valid;
   logic             req1_ready;
   logic [2:0]       req1_op;
   logic [31:0]      req1_src1;
   logic [31:0]      req1_src2;
   logic [TAG_W-1:0] req1_tag;

   logic             flush;
   logic             resp_valid;
   logic             resp_ready;
   logic             resp_id;
   logic [TAG_W-1:0] resp_tag;
   logic [31:0]      resp_data;
   logic             resp_illegal;

   modport master (
      output req0_valid, req0_op, req0_src1, req0_src2, req0_tag,
      input  req0_ready,
      output req1_valid, req1_op, req1_src1, req1_src2, req1_tag,
      input  req1_ready,
      output flush, resp_ready,
      input  resp_valid, resp_id, resp_tag, resp_data, resp_illegal
   );

   modport slave (
      input  req0_valid, req0_op, req0_src1, req0_src2, req0_tag,
      output req0_ready,
      input  req1_valid, req1_op, req1_src1, req1_src2, req1_tag,
      output req1_ready,
      input  flush, resp_ready,
      output resp_valid, resp_id, resp_tag, resp_data, resp_illegal
   );
endinterface

// File: rtl/bitmanip_share_arb.sv
// One registered bitmanip datapath shared round-robin between two requesters,
// with a one-deep tagged result stage feeding writeback.
module bitmanip_share_arb #(
   parameter int TAG_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   bitmanip_share_arb_if.slave bus
);

   function automatic logic [31:0] bm_result(input logic [2:0]  op,
                                             input logic [31:0] x,
                                             input logic [31:0] l);
      logic [31:0] r;
      logic [7:0]  bidx;
      logic [3:0]  nidx;
      r    = '0;
      bidx = '0;
      nidx = '0;
      case (op)
         3'd0: begin
            case (l[1:0])
               2'd0:    r = x;
               2'd1:    r = {x[23:0], x[31:24]};
               2'd2:    r = {x[15:0], x[31:16]};
               default: r = {x[7:0],  x[31:8]};
            endcase
         end
         3'd1: begin
            for (int b = 0; b < 4; b++)
               for (int i = 0; i < 8; i++)
                  r[8*b+i] = x[8*b+7-i];
         end
         3'd2: begin
            for (int i = 0; i < 16; i++) begin
               r[2*i]   = x[i];
               r[2*i+1] = x[i+16];
            end
         end
         3'd3: begin
            for (int i = 0; i < 16; i++) begin
               r[i]    = x[2*i];
               r[i+16] = x[2*i+1];
            end
         end
         3'd4: begin
            // out-of-range indices leave the lane at zero
            for (int k = 0; k < 4; k++) begin
               bidx = x[8*k +: 8];
               if (bidx < 8'd4)
                  r[8*k +: 8] = l[{bidx[1:0], 3'b000} +: 8];
            end
         end
         3'd5: begin
            for (int k = 0; k < 8; k++) begin
               nidx = x[4*k +: 4];
               if (nidx < 4'd8)
                  r[4*k +: 4] = l[{nidx[2:0], 2'b00} +: 4];
            end
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   logic             rr_last;
   logic             can_accept;
   logic             gnt0;
   logic             gnt1;
   logic             accept;
   logic [2:0]       sel_op;
   logic [31:0]      sel_src1;
   logic [31:0]      sel_src2;
   logic [TAG_W-1:0] sel_tag;
   logic [31:0]      calc_data;
   logic             calc_illegal;

   // readies depend only on valids, resp_ready, flush and rst
   always_comb begin
      can_accept     = !rst && !bus.flush && (!bus.resp_valid || bus.resp_ready);
      gnt0           = bus.req0_valid && (!bus.req1_valid || rr_last);
      gnt1           = bus.req1_valid && (!bus.req0_valid || !rr_last);
      bus.req0_ready = can_accept && gnt0;
      bus.req1_ready = can_accept && gnt1;
      accept         = bus.req0_ready || bus.req1_ready;
   end

   always_comb begin
      sel_op       = gnt1 ? bus.req1_op   : bus.req0_op;
      sel_src1     = gnt1 ? bus.req1_src1 : bus.req0_src1;
      sel_src2     = gnt1 ? bus.req1_src2 : bus.req0_src2;
      sel_tag      = gnt1 ? bus.req1_tag  : bus.req0_tag;
      calc_illegal = (sel_op == 3'd6) || (sel_op == 3'd7);
      calc_data    = bm_result(sel_op, sel_src1, sel_src2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.resp_valid   <= 1'b0;
         bus.resp_id      <= 1'b0;
         bus.resp_tag     <= '0;
         bus.resp_data    <= '0;
         bus.resp_illegal <= 1'b0;
         rr_last          <= 1'b1;
      end else if (accept) begin
         bus.resp_valid   <= 1'b1;
         bus.resp_id      <= gnt1;
         bus.resp_tag     <= sel_tag;
         bus.resp_data    <= calc_data;
         bus.resp_illegal <= calc_illegal;
         rr_last          <= gnt1;
      end else if (bus.flush || bus.resp_ready) begin
         bus.resp_valid   <= 1'b0;
      end
   end

endmodule
